// File: rtl/rs_alu_n_pkg.sv
// rs_alu_n_pkg: shared default sizes for the ALU reservation station.
// The top-level and entry parameters default to these values.
package rs_alu_n_pkg;

   localparam int unsigned RS_ENT_NUM = 8;   // entry count, power of two
   localparam int unsigned RS_WB_NUM  = 3;   // writeback buses
   localparam int unsigned RS_DATA_W  = 32;  // operand / immediate width
   localparam int unsigned RS_PC_W    = 32;  // pc width
   localparam int unsigned RS_TAG_W   = 6;   // rrf tag width
   localparam int unsigned RS_OP_W    = 4;   // alu op width
   localparam int unsigned RS_S1_W    = 2;   // src1-select width
   localparam int unsigned RS_S2_W    = 2;   // src2-select width

endpackage

// File: rtl/rs_alu_n_ent.sv
// rs_alu_n_ent: one reservation-station entry.
// Holds busy flag and instruction payload, captures missing operands from
// the writeback buses (both at dispatch and while waiting).
// Ports:
//   clk, rst_n        clock, async active-low reset
//   i_flush           clear busy
//   i_we              write dispatch payload into this entry
//   i_free            entry moved to the issue slot; clear busy
//   i_op..i_rrftag    dispatch payload
//   i_wb_vld/tag/res  writeback buses, bus 0 at LSBs
//   o_busy            entry occupied
//   o_ready_c         busy with both operands present (combinational)
//   o_op..o_rrftag    stored payload
module rs_alu_n_ent
   import rs_alu_n_pkg::*;
#(
   parameter int unsigned WB_NUM = RS_WB_NUM,
   parameter int unsigned DATA_W = RS_DATA_W,
   parameter int unsigned PC_W   = RS_PC_W,
   parameter int unsigned TAG_W  = RS_TAG_W,
   parameter int unsigned OP_W   = RS_OP_W,
   parameter int unsigned S1_W   = RS_S1_W,
   parameter int unsigned S2_W   = RS_S2_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_flush,
   input  logic                     i_we,
   input  logic                     i_free,
   input  logic [OP_W-1:0]          i_op,
   input  logic [S1_W-1:0]          i_src1_sel,
   input  logic [S2_W-1:0]          i_src2_sel,
   input  logic                     i_rs1_vld,
   input  logic                     i_rs2_vld,
   input  logic [DATA_W-1:0]        i_rs1,
   input  logic [DATA_W-1:0]        i_rs2,
   input  logic [PC_W-1:0]          i_pc,
   input  logic [DATA_W-1:0]        i_imm,
   input  logic [TAG_W-1:0]         i_rrftag,
   input  logic [WB_NUM-1:0]        i_wb_vld,
   input  logic [WB_NUM*TAG_W-1:0]  i_wb_tag,
   input  logic [WB_NUM*DATA_W-1:0] i_wb_res,
   output logic                     o_busy,
   output logic                     o_ready_c,
   output logic [OP_W-1:0]          o_op,
   output logic [S1_W-1:0]          o_src1_sel,
   output logic [S2_W-1:0]          o_src2_sel,
   output logic [DATA_W-1:0]        o_rs1,
   output logic [DATA_W-1:0]        o_rs2,
   output logic [PC_W-1:0]          o_pc,
   output logic [DATA_W-1:0]        o_imm,
   output logic [TAG_W-1:0]         o_rrftag
);

   logic              busy_q, busy_d;
   logic [OP_W-1:0]   op_q, op_d;
   logic [S1_W-1:0]   s1_q, s1_d;
   logic [S2_W-1:0]   s2_q, s2_d;
   logic              rs1_vld_q, rs1_vld_d;
   logic              rs2_vld_q, rs2_vld_d;
   logic [DATA_W-1:0] rs1_q, rs1_d;
   logic [DATA_W-1:0] rs2_q, rs2_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [DATA_W-1:0] imm_q, imm_d;
   logic [TAG_W-1:0]  rrftag_q, rrftag_d;

   // Operand capture: a missing operand carries its producer tag in the low
   // bits; scanning buses downward lets the lowest matching bus win.
   function automatic logic [DATA_W:0] capture(
      input logic                     vld,
      input logic [DATA_W-1:0]        val,
      input logic [WB_NUM-1:0]        wb_vld,
      input logic [WB_NUM*TAG_W-1:0]  wb_tag,
      input logic [WB_NUM*DATA_W-1:0] wb_res
   );
      logic [DATA_W:0] r;
      r = {vld, val};
      if (!vld) begin
         for (int b = int'(WB_NUM) - 1; b >= 0; b--) begin
            if (wb_vld[b] && (wb_tag[b*TAG_W +: TAG_W] == val[TAG_W-1:0])) begin
               r = {1'b1, wb_res[b*DATA_W +: DATA_W]};
            end
         end
      end
      return r;
   endfunction

   // Next state: flush beats dispatch write beats issue free.
   always_comb begin
      busy_d    = busy_q;
      op_d      = op_q;
      s1_d      = s1_q;
      s2_d      = s2_q;
      rs1_vld_d = rs1_vld_q;
      rs2_vld_d = rs2_vld_q;
      rs1_d     = rs1_q;
      rs2_d     = rs2_q;
      pc_d      = pc_q;
      imm_d     = imm_q;
      rrftag_d  = rrftag_q;
      if (busy_q) begin
         {rs1_vld_d, rs1_d} = capture(rs1_vld_q, rs1_q, i_wb_vld, i_wb_tag, i_wb_res);
         {rs2_vld_d, rs2_d} = capture(rs2_vld_q, rs2_q, i_wb_vld, i_wb_tag, i_wb_res);
      end
      if (i_flush) begin
         busy_d = 1'b0;
      end else if (i_we) begin
         busy_d   = 1'b1;
         op_d     = i_op;
         s1_d     = i_src1_sel;
         s2_d     = i_src2_sel;
         pc_d     = i_pc;
         imm_d    = i_imm;
         rrftag_d = i_rrftag;
         {rs1_vld_d, rs1_d} = capture(i_rs1_vld, i_rs1, i_wb_vld, i_wb_tag, i_wb_res);
         {rs2_vld_d, rs2_d} = capture(i_rs2_vld, i_rs2, i_wb_vld, i_wb_tag, i_wb_res);
      end else if (i_free) begin
         busy_d = 1'b0;
      end
   end

   // Entry state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q    <= 1'b0;
         op_q      <= '0;
         s1_q      <= '0;
         s2_q      <= '0;
         rs1_vld_q <= 1'b0;
         rs2_vld_q <= 1'b0;
         rs1_q     <= '0;
         rs2_q     <= '0;
         pc_q      <= '0;
         imm_q     <= '0;
         rrftag_q  <= '0;
      end else begin
         busy_q    <= busy_d;
         op_q      <= op_d;
         s1_q      <= s1_d;
         s2_q      <= s2_d;
         rs1_vld_q <= rs1_vld_d;
         rs2_vld_q <= rs2_vld_d;
         rs1_q     <= rs1_d;
         rs2_q     <= rs2_d;
         pc_q      <= pc_d;
         imm_q     <= imm_d;
         rrftag_q  <= rrftag_d;
      end
   end

   assign o_busy     = busy_q;
   assign o_ready_c  = busy_q & rs1_vld_q & rs2_vld_q;
   assign o_op       = op_q;
   assign o_src1_sel = s1_q;
   assign o_src2_sel = s2_q;
   assign o_rs1      = rs1_q;
   assign o_rs2      = rs2_q;
   assign o_pc       = pc_q;
   assign o_imm      = imm_q;
   assign o_rrftag   = rrftag_q;

endmodule

// File: rtl/rs_alu_n.sv
// rs_alu_n: ALU reservation station between dual dispatch and ALU issue.
// Allocates up to two free entries per cycle, wakes operands from the
// writeback buses, selects one ready entry per cycle into a registered
// issue slot with valid/ack handshake, and supports a full flush.
// Build option: RS_AGE_SEL_EN defined -> oldest ready entry is selected
// through an age matrix; undefined -> lowest-index ready entry.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   i_flush, i_stall            flush all state / block dispatch
//   o_busy_vec, o_free_cnt      occupancy and free-entry count
//   o_alloc_rdy                 at least two entries free
//   i_alloc_vld_k, i_dp_*_k     dispatch slot k (1 is older)
//   i_wb_vld/tag/res            writeback buses, bus 0 at LSBs
//   o_is_vld, i_is_ack          issue handshake
//   o_is_*                      registered issue payload
module rs_alu_n
   import rs_alu_n_pkg::*;
#(
   parameter int unsigned ENT_NUM = RS_ENT_NUM,
   parameter int unsigned ENT_SEL = $clog2(ENT_NUM),
   parameter int unsigned WB_NUM  = RS_WB_NUM,
   parameter int unsigned DATA_W  = RS_DATA_W,
   parameter int unsigned PC_W    = RS_PC_W,
   parameter int unsigned TAG_W   = RS_TAG_W,
   parameter int unsigned OP_W    = RS_OP_W,
   parameter int unsigned S1_W    = RS_S1_W,
   parameter int unsigned S2_W    = RS_S2_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_flush,
   input  logic                     i_stall,
   output logic [ENT_NUM-1:0]       o_busy_vec,
   output logic [ENT_SEL:0]         o_free_cnt,
   output logic                     o_alloc_rdy,
   input  logic                     i_alloc_vld_1,
   input  logic [OP_W-1:0]          i_dp_op_1,
   input  logic [S1_W-1:0]          i_dp_src1_sel_1,
   input  logic [S2_W-1:0]          i_dp_src2_sel_1,
   input  logic                     i_dp_rs1_vld_1,
   input  logic                     i_dp_rs2_vld_1,
   input  logic [DATA_W-1:0]        i_dp_rs1_1,
   input  logic [DATA_W-1:0]        i_dp_rs2_1,
   input  logic [PC_W-1:0]          i_dp_pc_1,
   input  logic [DATA_W-1:0]        i_dp_imm_1,
   input  logic [TAG_W-1:0]         i_dp_rrftag_1,
   input  logic                     i_alloc_vld_2,
   input  logic [OP_W-1:0]          i_dp_op_2,
   input  logic [S1_W-1:0]          i_dp_src1_sel_2,
   input  logic [S2_W-1:0]          i_dp_src2_sel_2,
   input  logic                     i_dp_rs1_vld_2,
   input  logic                     i_dp_rs2_vld_2,
   input  logic [DATA_W-1:0]        i_dp_rs1_2,
   input  logic [DATA_W-1:0]        i_dp_rs2_2,
   input  logic [PC_W-1:0]          i_dp_pc_2,
   input  logic [DATA_W-1:0]        i_dp_imm_2,
   input  logic [TAG_W-1:0]         i_dp_rrftag_2,
   input  logic [WB_NUM-1:0]        i_wb_vld,
   input  logic [WB_NUM*TAG_W-1:0]  i_wb_tag,
   input  logic [WB_NUM*DATA_W-1:0] i_wb_res,
   output logic                     o_is_vld,
   input  logic                     i_is_ack,
   output logic [OP_W-1:0]          o_is_op,
   output logic [S1_W-1:0]          o_is_src1_sel,
   output logic [S2_W-1:0]          o_is_src2_sel,
   output logic [DATA_W-1:0]        o_is_rs1,
   output logic [DATA_W-1:0]        o_is_rs2,
   output logic [PC_W-1:0]          o_is_pc,
   output logic [DATA_W-1:0]        o_is_imm,
   output logic [TAG_W-1:0]         o_is_rrftag
);

   localparam int unsigned CNT_W = ENT_SEL + 1;

   logic [ENT_NUM-1:0] busy;
   logic [ENT_NUM-1:0] ready_c;
   logic [ENT_NUM-1:0] cand;
   logic [ENT_NUM-1:0] we1_mask, we2_mask, free_mask, busy_nxt;
   logic [ENT_SEL-1:0] alloc1_idx, alloc2_idx, sel_idx;
   logic               found1, found2, sel_vld, disp_ok, we1, we2;

   logic [OP_W-1:0]    ent_op     [ENT_NUM];
   logic [S1_W-1:0]    ent_s1     [ENT_NUM];
   logic [S2_W-1:0]    ent_s2     [ENT_NUM];
   logic [DATA_W-1:0]  ent_rs1    [ENT_NUM];
   logic [DATA_W-1:0]  ent_rs2    [ENT_NUM];
   logic [PC_W-1:0]    ent_pc     [ENT_NUM];
   logic [DATA_W-1:0]  ent_imm    [ENT_NUM];
   logic [TAG_W-1:0]   ent_rrftag [ENT_NUM];

   logic [CNT_W-1:0]   free_cnt_q, free_cnt_d;
   logic               alloc_rdy_q, alloc_rdy_d;
   logic               is_vld_q, is_vld_d;
   logic [OP_W-1:0]    is_op_q, is_op_d;
   logic [S1_W-1:0]    is_s1_q, is_s1_d;
   logic [S2_W-1:0]    is_s2_q, is_s2_d;
   logic [DATA_W-1:0]  is_rs1_q, is_rs1_d;
   logic [DATA_W-1:0]  is_rs2_q, is_rs2_d;
   logic [PC_W-1:0]    is_pc_q, is_pc_d;
   logic [DATA_W-1:0]  is_imm_q, is_imm_d;
   logic [TAG_W-1:0]   is_rrftag_q, is_rrftag_d;

   // Allocation: first and second free entries, lowest index first.
   always_comb begin
      alloc1_idx = '0;
      alloc2_idx = '0;
      found1     = 1'b0;
      found2     = 1'b0;
      for (int i = 0; i < int'(ENT_NUM); i++) begin
         if (!busy[i]) begin
            if (!found1) begin
               found1     = 1'b1;
               alloc1_idx = ENT_SEL'(i);
            end else if (!found2) begin
               found2     = 1'b1;
               alloc2_idx = ENT_SEL'(i);
            end
         end
      end
   end

   // Dispatch gating; inst2 alone is illegal and dropped.
   always_comb begin
      disp_ok  = !i_stall && alloc_rdy_q && !i_flush;
      we1      = disp_ok && i_alloc_vld_1 && found1;
      we2      = disp_ok && i_alloc_vld_1 && i_alloc_vld_2 && found2;
      we1_mask = '0;
      we2_mask = '0;
      if (we1) we1_mask[alloc1_idx] = 1'b1;
      if (we2) we2_mask[alloc2_idx] = 1'b1;
   end

   // Entry array.
   for (genvar g = 0; g < int'(ENT_NUM); g++) begin : g_ent
      rs_alu_n_ent #(
         .WB_NUM (WB_NUM),
         .DATA_W (DATA_W),
         .PC_W   (PC_W),
         .TAG_W  (TAG_W),
         .OP_W   (OP_W),
         .S1_W   (S1_W),
         .S2_W   (S2_W)
      ) u_ent (
         .clk        (clk),
         .rst_n      (rst_n),
         .i_flush    (i_flush),
         .i_we       (we1_mask[g] | we2_mask[g]),
         .i_free     (free_mask[g]),
         .i_op       (we2_mask[g] ? i_dp_op_2       : i_dp_op_1),
         .i_src1_sel (we2_mask[g] ? i_dp_src1_sel_2 : i_dp_src1_sel_1),
         .i_src2_sel (we2_mask[g] ? i_dp_src2_sel_2 : i_dp_src2_sel_1),
         .i_rs1_vld  (we2_mask[g] ? i_dp_rs1_vld_2  : i_dp_rs1_vld_1),
         .i_rs2_vld  (we2_mask[g] ? i_dp_rs2_vld_2  : i_dp_rs2_vld_1),
         .i_rs1      (we2_mask[g] ? i_dp_rs1_2      : i_dp_rs1_1),
         .i_rs2      (we2_mask[g] ? i_dp_rs2_2      : i_dp_rs2_1),
         .i_pc       (we2_mask[g] ? i_dp_pc_2       : i_dp_pc_1),
         .i_imm      (we2_mask[g] ? i_dp_imm_2      : i_dp_imm_1),
         .i_rrftag   (we2_mask[g] ? i_dp_rrftag_2   : i_dp_rrftag_1),
         .i_wb_vld   (i_wb_vld),
         .i_wb_tag   (i_wb_tag),
         .i_wb_res   (i_wb_res),
         .o_busy     (busy[g]),
         .o_ready_c  (ready_c[g]),
         .o_op       (ent_op[g]),
         .o_src1_sel (ent_s1[g]),
         .o_src2_sel (ent_s2[g]),
         .o_rs1      (ent_rs1[g]),
         .o_rs2      (ent_rs2[g]),
         .o_pc       (ent_pc[g]),
         .o_imm      (ent_imm[g]),
         .o_rrftag   (ent_rrftag[g])
      );
   end

`ifdef RS_AGE_SEL_EN
   // age_q[i][j] = 1: entry i is older than entry j. Only busy pairs matter;
   // a newly written entry becomes younger than everything else.
   logic [ENT_NUM-1:0][ENT_NUM-1:0] age_q, age_d;

   always_comb begin
      age_d = age_q;
      if (we1) begin
         age_d[alloc1_idx] = '0;
         for (int j = 0; j < int'(ENT_NUM); j++) begin
            age_d[j][alloc1_idx] = (ENT_SEL'(j) != alloc1_idx);
         end
      end
      if (we2) begin
         age_d[alloc2_idx] = '0;
         for (int j = 0; j < int'(ENT_NUM); j++) begin
            age_d[j][alloc2_idx] = (ENT_SEL'(j) != alloc2_idx);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) age_q <= '0;
      else        age_q <= age_d;
   end

   // Candidate: ready with no older ready entry.
   always_comb begin : oldest_ready
      logic older;
      cand = '0;
      for (int i = 0; i < int'(ENT_NUM); i++) begin
         older = 1'b0;
         for (int j = 0; j < int'(ENT_NUM); j++) begin
            if ((j != i) && ready_c[j] && age_q[j][i]) older = 1'b1;
         end
         cand[i] = ready_c[i] && !older;
      end
   end
`else
   assign cand = ready_c;
`endif

   // Lowest-index candidate.
   always_comb begin
      sel_idx = '0;
      sel_vld = 1'b0;
      for (int i = int'(ENT_NUM) - 1; i >= 0; i--) begin
         if (cand[i]) begin
            sel_idx = ENT_SEL'(i);
            sel_vld = 1'b1;
         end
      end
   end

   // Issue slot: reload when empty or acked; selected entry freed same edge.
   always_comb begin
      is_vld_d    = is_vld_q;
      is_op_d     = is_op_q;
      is_s1_d     = is_s1_q;
      is_s2_d     = is_s2_q;
      is_rs1_d    = is_rs1_q;
      is_rs2_d    = is_rs2_q;
      is_pc_d     = is_pc_q;
      is_imm_d    = is_imm_q;
      is_rrftag_d = is_rrftag_q;
      free_mask   = '0;
      if (i_flush) begin
         is_vld_d = 1'b0;
      end else if (!is_vld_q || i_is_ack) begin
         is_vld_d = sel_vld;
         if (sel_vld) begin
            is_op_d     = ent_op[sel_idx];
            is_s1_d     = ent_s1[sel_idx];
            is_s2_d     = ent_s2[sel_idx];
            is_rs1_d    = ent_rs1[sel_idx];
            is_rs2_d    = ent_rs2[sel_idx];
            is_pc_d     = ent_pc[sel_idx];
            is_imm_d    = ent_imm[sel_idx];
            is_rrftag_d = ent_rrftag[sel_idx];
            free_mask[sel_idx] = 1'b1;
         end
      end
   end

   // Free count registered alongside the busy bits it describes.
   always_comb begin
      busy_nxt   = i_flush ? '0 : ((busy & ~free_mask) | we1_mask | we2_mask);
      free_cnt_d = '0;
      for (int i = 0; i < int'(ENT_NUM); i++) begin
         free_cnt_d = free_cnt_d + CNT_W'(~busy_nxt[i]);
      end
      alloc_rdy_d = (free_cnt_d >= CNT_W'(2));
   end

   // Top-level state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         free_cnt_q  <= CNT_W'(ENT_NUM);
         alloc_rdy_q <= 1'b1;
         is_vld_q    <= 1'b0;
         is_op_q     <= '0;
         is_s1_q     <= '0;
         is_s2_q     <= '0;
         is_rs1_q    <= '0;
         is_rs2_q    <= '0;
         is_pc_q     <= '0;
         is_imm_q    <= '0;
         is_rrftag_q <= '0;
      end else begin
         free_cnt_q  <= free_cnt_d;
         alloc_rdy_q <= alloc_rdy_d;
         is_vld_q    <= is_vld_d;
         is_op_q     <= is_op_d;
         is_s1_q     <= is_s1_d;
         is_s2_q     <= is_s2_d;
         is_rs1_q    <= is_rs1_d;
         is_rs2_q    <= is_rs2_d;
         is_pc_q     <= is_pc_d;
         is_imm_q    <= is_imm_d;
         is_rrftag_q <= is_rrftag_d;
      end
   end

   assign o_busy_vec    = busy;
   assign o_free_cnt    = free_cnt_q;
   assign o_alloc_rdy   = alloc_rdy_q;
   assign o_is_vld      = is_vld_q;
   assign o_is_op       = is_op_q;
   assign o_is_src1_sel = is_s1_q;
   assign o_is_src2_sel = is_s2_q;
   assign o_is_rs1      = is_rs1_q;
   assign o_is_rs2      = is_rs2_q;
   assign o_is_pc       = is_pc_q;
   assign o_is_imm      = is_imm_q;
   assign o_is_rrftag   = is_rrftag_q;

endmodule

// File: tb/tb_rs_alu_n.sv
// tb_rs_alu_n: directed self-checking bench for rs_alu_n (default sizes).
// Expected issue order in the age test depends on RS_AGE_SEL_EN.
module tb_rs_alu_n;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_flush, i_stall;
   logic [7:0]  o_busy_vec;
   logic [3:0]  o_free_cnt;
   logic        o_alloc_rdy;
   logic        i_alloc_vld_1, i_alloc_vld_2;
   logic [3:0]  i_dp_op_1, i_dp_op_2;
   logic [1:0]  i_dp_src1_sel_1, i_dp_src1_sel_2, i_dp_src2_sel_1, i_dp_src2_sel_2;
   logic        i_dp_rs1_vld_1, i_dp_rs1_vld_2, i_dp_rs2_vld_1, i_dp_rs2_vld_2;
   logic [31:0] i_dp_rs1_1, i_dp_rs1_2, i_dp_rs2_1, i_dp_rs2_2;
   logic [31:0] i_dp_pc_1, i_dp_pc_2, i_dp_imm_1, i_dp_imm_2;
   logic [5:0]  i_dp_rrftag_1, i_dp_rrftag_2;
   logic [2:0]  i_wb_vld;
   logic [17:0] i_wb_tag;
   logic [95:0] i_wb_res;
   logic        o_is_vld, i_is_ack;
   logic [3:0]  o_is_op;
   logic [1:0]  o_is_src1_sel, o_is_src2_sel;
   logic [31:0] o_is_rs1, o_is_rs2, o_is_pc, o_is_imm;
   logic [5:0]  o_is_rrftag;

   int n_chk = 0;
   int n_err = 0;

`ifdef RS_AGE_SEL_EN
   localparam logic [5:0] AGE_T1 = 6'd57, AGE_T2 = 6'd60, AGE_T3 = 6'd61;
`else
   localparam logic [5:0] AGE_T1 = 6'd60, AGE_T2 = 6'd61, AGE_T3 = 6'd57;
`endif

   rs_alu_n dut (
      .clk(clk), .rst_n(rst_n), .i_flush(i_flush), .i_stall(i_stall),
      .o_busy_vec(o_busy_vec), .o_free_cnt(o_free_cnt), .o_alloc_rdy(o_alloc_rdy),
      .i_alloc_vld_1(i_alloc_vld_1), .i_dp_op_1(i_dp_op_1),
      .i_dp_src1_sel_1(i_dp_src1_sel_1), .i_dp_src2_sel_1(i_dp_src2_sel_1),
      .i_dp_rs1_vld_1(i_dp_rs1_vld_1), .i_dp_rs2_vld_1(i_dp_rs2_vld_1),
      .i_dp_rs1_1(i_dp_rs1_1), .i_dp_rs2_1(i_dp_rs2_1), .i_dp_pc_1(i_dp_pc_1),
      .i_dp_imm_1(i_dp_imm_1), .i_dp_rrftag_1(i_dp_rrftag_1),
      .i_alloc_vld_2(i_alloc_vld_2), .i_dp_op_2(i_dp_op_2),
      .i_dp_src1_sel_2(i_dp_src1_sel_2), .i_dp_src2_sel_2(i_dp_src2_sel_2),
      .i_dp_rs1_vld_2(i_dp_rs1_vld_2), .i_dp_rs2_vld_2(i_dp_rs2_vld_2),
      .i_dp_rs1_2(i_dp_rs1_2), .i_dp_rs2_2(i_dp_rs2_2), .i_dp_pc_2(i_dp_pc_2),
      .i_dp_imm_2(i_dp_imm_2), .i_dp_rrftag_2(i_dp_rrftag_2),
      .i_wb_vld(i_wb_vld), .i_wb_tag(i_wb_tag), .i_wb_res(i_wb_res),
      .o_is_vld(o_is_vld), .i_is_ack(i_is_ack), .o_is_op(o_is_op),
      .o_is_src1_sel(o_is_src1_sel), .o_is_src2_sel(o_is_src2_sel),
      .o_is_rs1(o_is_rs1), .o_is_rs2(o_is_rs2), .o_is_pc(o_is_pc),
      .o_is_imm(o_is_imm), .o_is_rrftag(o_is_rrftag)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Dispatch slot k; op/sel/pc/imm are derived from the rrf tag.
   task automatic dp(input int k, input logic vld, input logic r1v, input logic [31:0] r1,
                     input logic r2v, input logic [31:0] r2, input logic [5:0] tag);
      if (k == 1) begin
         i_alloc_vld_1 = vld; i_dp_rs1_vld_1 = r1v; i_dp_rs1_1 = r1;
         i_dp_rs2_vld_1 = r2v; i_dp_rs2_1 = r2; i_dp_rrftag_1 = tag;
         i_dp_op_1 = tag[3:0]; i_dp_src1_sel_1 = tag[1:0]; i_dp_src2_sel_1 = tag[2:1];
         i_dp_pc_1 = 32'h1000 + 32'(tag); i_dp_imm_1 = 32'(tag) * 2;
      end else begin
         i_alloc_vld_2 = vld; i_dp_rs1_vld_2 = r1v; i_dp_rs1_2 = r1;
         i_dp_rs2_vld_2 = r2v; i_dp_rs2_2 = r2; i_dp_rrftag_2 = tag;
         i_dp_op_2 = tag[3:0]; i_dp_src1_sel_2 = tag[1:0]; i_dp_src2_sel_2 = tag[2:1];
         i_dp_pc_2 = 32'h1000 + 32'(tag); i_dp_imm_2 = 32'(tag) * 2;
      end
   endtask

   task automatic dp_clr();
      i_alloc_vld_1 = 1'b0;
      i_alloc_vld_2 = 1'b0;
   endtask

   task automatic wb(input int b, input logic [5:0] tag, input logic [31:0] res);
      i_wb_vld[b] = 1'b1;
      i_wb_tag[b*6 +: 6] = tag;
      i_wb_res[b*32 +: 32] = res;
   endtask

   initial begin
      rst_n = 1'b0; i_flush = 1'b0; i_stall = 1'b0; i_is_ack = 1'b0;
      i_wb_vld = '0; i_wb_tag = '0; i_wb_res = '0;
      dp(1, 1'b0, 1'b0, 0, 1'b0, 0, 6'd0);
      dp(2, 1'b0, 1'b0, 0, 1'b0, 0, 6'd0);
      step(); step();
      chk("rst_busy", 64'(o_busy_vec), 64'h0);
      chk("rst_free", 64'(o_free_cnt), 64'd8);
      chk("rst_rdy", 64'(o_alloc_rdy), 64'd1);
      chk("rst_vld", 64'(o_is_vld), 64'd0);
      chk("rst_tag", 64'(o_is_rrftag), 64'd0);
      chk("rst_rs1", 64'(o_is_rs1), 64'd0);
      rst_n = 1'b1;
      step();

      // Two ready instructions, continuous ack.
      i_is_ack = 1'b1;
      dp(1, 1'b1, 1'b1, 32'h11, 1'b1, 32'h22, 6'd5);
      dp(2, 1'b1, 1'b1, 32'h33, 1'b1, 32'h44, 6'd6);
      step(); dp_clr();
      chk("t1_busy", 64'(o_busy_vec), 64'h03);
      chk("t1_vld0", 64'(o_is_vld), 64'd0);
      chk("t1_free6", 64'(o_free_cnt), 64'd6);
      step();
      chk("t1_vld1", 64'(o_is_vld), 64'd1);
      chk("t1_tag5", 64'(o_is_rrftag), 64'd5);
      chk("t1_rs1", 64'(o_is_rs1), 64'h11);
      chk("t1_rs2", 64'(o_is_rs2), 64'h22);
      chk("t1_op", 64'(o_is_op), 64'd5);
      chk("t1_s1", 64'(o_is_src1_sel), 64'd1);
      chk("t1_s2", 64'(o_is_src2_sel), 64'd2);
      chk("t1_pc", 64'(o_is_pc), 64'h1005);
      chk("t1_imm", 64'(o_is_imm), 64'd10);
      chk("t1_free7", 64'(o_free_cnt), 64'd7);
      step();
      chk("t1_tag6", 64'(o_is_rrftag), 64'd6);
      chk("t1_rs1b", 64'(o_is_rs1), 64'h33);
      chk("t1_free8", 64'(o_free_cnt), 64'd8);
      step();
      chk("t1_idle", 64'(o_is_vld), 64'd0);

      // Stall drops dispatch; inst2 alone is ignored.
      i_stall = 1'b1;
      dp(1, 1'b1, 1'b1, 32'h1, 1'b1, 32'h2, 6'd7);
      step(); i_stall = 1'b0; dp_clr();
      chk("stall_busy", 64'(o_busy_vec), 64'h0);
      dp(2, 1'b1, 1'b1, 32'h1, 1'b1, 32'h2, 6'd8);
      step(); dp_clr();
      chk("inst2only_busy", 64'(o_busy_vec), 64'h0);
      step();
      chk("inst2only_vld", 64'(o_is_vld), 64'd0);

      // Wakeup from bus 1 while bus 0 carries a different tag.
      dp(1, 1'b1, 1'b0, 32'd9, 1'b1, 32'd7, 6'd10);
      step(); dp_clr();
      chk("t2_busy", 64'(o_busy_vec), 64'h01);
      step();
      chk("t2_wait", 64'(o_is_vld), 64'd0);
      wb(0, 6'd8, 32'hBAD); wb(1, 6'd9, 32'hDEAD);
      step(); i_wb_vld = '0;
      chk("t2_w1", 64'(o_is_vld), 64'd0);
      step();
      chk("t2_vld", 64'(o_is_vld), 64'd1);
      chk("t2_rs1", 64'(o_is_rs1), 64'hDEAD);
      chk("t2_rs2", 64'(o_is_rs2), 64'd7);
      chk("t2_tag", 64'(o_is_rrftag), 64'd10);
      step();
      chk("t2_done", 64'(o_is_vld), 64'd0);

      // Dispatch-time bypass from bus 2.
      dp(1, 1'b1, 1'b0, 32'd3, 1'b1, 32'h66, 6'd11);
      wb(2, 6'd3, 32'h55);
      step(); dp_clr(); i_wb_vld = '0;
      chk("t3_d1", 64'(o_is_vld), 64'd0);
      step();
      chk("t3_vld", 64'(o_is_vld), 64'd1);
      chk("t3_rs1", 64'(o_is_rs1), 64'h55);
      chk("t3_tag", 64'(o_is_rrftag), 64'd11);
      step();

      // Full station with a held issue slot.
      i_is_ack = 1'b0;
      dp(1, 1'b1, 1'b1, 32'h19, 1'b1, 32'h0, 6'd19);
      step(); dp_clr();
      step();
      chk("t4_slot", 64'(o_is_rrftag), 64'd19);
      for (int p = 0; p < 4; p++) begin
         dp(1, 1'b1, 1'b0, 32'd33, 1'b1, 32'h0, 6'(20 + 2*p));
         dp(2, 1'b1, 1'b0, 32'd33, 1'b1, 32'h0, 6'(21 + 2*p));
         step();
      end
      chk("t4_full", 64'(o_busy_vec), 64'hFF);
      chk("t4_free0", 64'(o_free_cnt), 64'd0);
      chk("t4_rdy0", 64'(o_alloc_rdy), 64'd0);
      dp(1, 1'b1, 1'b1, 32'h1, 1'b1, 32'h1, 6'd28);
      dp(2, 1'b1, 1'b1, 32'h1, 1'b1, 32'h1, 6'd29);
      for (int c = 0; c < 5; c++) begin
         step();
         chk("t4_hold_busy", 64'(o_busy_vec), 64'hFF);
         chk("t4_hold_vld", 64'(o_is_vld), 64'd1);
         chk("t4_hold_tag", 64'(o_is_rrftag), 64'd19);
         chk("t4_hold_rs1", 64'(o_is_rs1), 64'h19);
      end

      // Flush of a full station with ack and dispatch present.
      i_flush = 1'b1; i_is_ack = 1'b1;
      step(); i_flush = 1'b0; dp_clr();
      chk("t5_busy", 64'(o_busy_vec), 64'h0);
      chk("t5_vld", 64'(o_is_vld), 64'd0);
      chk("t5_free", 64'(o_free_cnt), 64'd8);
      chk("t5_rdy", 64'(o_alloc_rdy), 64'd1);

      // Flush coinciding with an accepted-looking dispatch and ack.
      i_is_ack = 1'b0;
      dp(1, 1'b1, 1'b1, 32'h1, 1'b1, 32'h1, 6'd30);
      dp(2, 1'b1, 1'b1, 32'h1, 1'b1, 32'h1, 6'd31);
      step(); dp_clr();
      step();
      chk("t5b_slot", 64'(o_is_rrftag), 64'd30);
      chk("t5b_busy", 64'(o_busy_vec), 64'h02);
      dp(1, 1'b1, 1'b1, 32'h1, 1'b1, 32'h1, 6'd32);
      dp(2, 1'b1, 1'b1, 32'h1, 1'b1, 32'h1, 6'd33);
      i_flush = 1'b1; i_is_ack = 1'b1;
      step(); i_flush = 1'b0; dp_clr();
      chk("t5b_busy0", 64'(o_busy_vec), 64'h0);
      chk("t5b_vld0", 64'(o_is_vld), 64'd0);
      chk("t5b_free8", 64'(o_free_cnt), 64'd8);
      step();
      chk("t5b_after", 64'(o_is_vld), 64'd0);

      // Select order: entry 7 older than re-used entries 0 and 1.
      for (int p = 0; p < 4; p++) begin
         dp(1, 1'b1, 1'b0, 32'(40 + 2*p), 1'b1, 32'h0, 6'(50 + 2*p));
         dp(2, 1'b1, 1'b0, 32'(41 + 2*p), 1'b1, 32'h0, 6'(51 + 2*p));
         step();
      end
      dp_clr();
      chk("t6_full", 64'(o_busy_vec), 64'hFF);
      wb(0, 6'd40, 32'h400); wb(1, 6'd41, 32'h410);
      step(); i_wb_vld = '0;
      chk("t6_w", 64'(o_is_vld), 64'd0);
      step();
      chk("t6_tag50", 64'(o_is_rrftag), 64'd50);
      chk("t6_rs1", 64'(o_is_rs1), 64'h400);
      step();
      chk("t6_tag51", 64'(o_is_rrftag), 64'd51);
      chk("t6_free2", 64'(o_free_cnt), 64'd2);
      chk("t6_busy", 64'(o_busy_vec), 64'hFC);
      dp(1, 1'b1, 1'b1, 32'h600, 1'b1, 32'h0, 6'd60);
      dp(2, 1'b1, 1'b1, 32'h610, 1'b1, 32'h0, 6'd61);
      wb(2, 6'd47, 32'h470);
      step(); dp_clr(); i_wb_vld = '0;
      chk("t6_gap", 64'(o_is_vld), 64'd0);
      chk("t6_busy_ff", 64'(o_busy_vec), 64'hFF);
      step();
      chk("t6_first", 64'(o_is_rrftag), 64'(AGE_T1));
      step();
      chk("t6_second", 64'(o_is_rrftag), 64'(AGE_T2));
      step();
      chk("t6_third", 64'(o_is_rrftag), 64'(AGE_T3));
      step();
      chk("t6_empty", 64'(o_is_vld), 64'd0);
      chk("t6_left", 64'(o_busy_vec), 64'h7C);

      i_flush = 1'b1;
      step(); i_flush = 1'b0;
      chk("end_busy", 64'(o_busy_vec), 64'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
